softmax_row_ctrl: RTL

Row-level initiator for the serial softmax engine in the attention datapath. Collects one row of NUM attention scores from a valid/ready stream and tracks the running row maximum. Subtracts that maximum from every score (safe-softmax normalisation), then drives the engine's hold-start request protocol. Streams the returned probabilities out one word per beat, with a last flag.

---
 rtl/mha_pkg.sv | 29 ++
 rtl/softmax_row_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mha_pkg.sv
// Shared definitions for the multi-head-attention datapath: FSM state
// encoding, word-width constants and the saturating subtract.
package mha_pkg;

  // Word width of scores and probabilities in the attention datapath.
  localparam int SM_D_W = 16;

  // Most negative and most positive D_W-bit two's-complement values.
  localparam logic [SM_D_W-1:0] SM_MIN = {1'b1, {(SM_D_W-1){1'b0}}};
  localparam logic [SM_D_W-1:0] SM_MAX = {1'b0, {(SM_D_W-1){1'b1}}};

  // Row controller states, one-hot.
  typedef enum logic [3:0] {
    S_LOAD = 4'b0001,
    S_SUB  = 4'b0010,
    S_RUN  = 4'b0100,
    S_OUT  = 4'b1000
  } state_e;

  // a - b computed one bit wider, clamped back into the D_W-bit signed range.
  function automatic logic [SM_D_W-1:0] sat_sub(input logic [SM_D_W-1:0] a,
                                                input logic [SM_D_W-1:0] b);
    logic [SM_D_W:0] diff;
    diff = {a[SM_D_W-1], a} - {b[SM_D_W-1], b};
    if (diff[SM_D_W] != diff[SM_D_W-1]) sat_sub = diff[SM_D_W] ? SM_MIN : SM_MAX;
    else                                sat_sub = diff[SM_D_W-1:0];
  endfunction

endpackage

// File: rtl/softmax_row_ctrl.sv
// Row-level initiator for the serial softmax engine: loads a row of scores,
// subtracts the row maximum, holds the engine start request, and streams the
// returned probabilities out with a last flag.
module softmax_row_ctrl
  import mha_pkg::*;
#(
  parameter int D_W = SM_D_W,  // must match the package word width
  parameter int NUM = 16       // words per row, at least 2
) (
  input  logic               I_CLK,
  input  logic               I_RST_N,
  input  logic               I_IN_VLD,
  output logic               O_IN_RDY,
  input  logic [D_W-1:0]     I_IN_DATA,
  output logic               O_SM_START,
  output logic [D_W*NUM-1:0] O_SM_DATA,
  input  logic               I_SM_VLD,
  input  logic [D_W*NUM-1:0] I_SM_DATA,
  output logic               O_OUT_VLD,
  input  logic               I_OUT_RDY,
  output logic [D_W-1:0]     O_OUT_DATA,
  output logic               O_OUT_LAST,
  output logic               O_BUSY
);

  localparam int CNT_W = $clog2(NUM) + 1;
  localparam int IDX_W = $clog2(NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM - 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [D_W-1:0]     r_max;
  logic               r_sm_start;
  logic [D_W*NUM-1:0] r_sm_data;
  logic [D_W-1:0]     r_score [NUM];
  logic [D_W-1:0]     r_res   [NUM];
  logic [D_W*NUM-1:0] w_norm;
  logic [IDX_W-1:0]   w_idx;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_cnt_last;

  assign w_idx      = r_cnt[IDX_W-1:0];
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_in_hs    = I_IN_VLD && O_IN_RDY;
  assign w_out_hs   = O_OUT_VLD && I_OUT_RDY;

  // Gate start low in the done cycle so the engine, idle then, cannot restart.
  assign O_SM_START = r_sm_start && !I_SM_VLD;
  assign O_SM_DATA  = r_sm_data;

  // Safe-softmax normalisation: every score minus the row max, saturated.
  for (genvar k = 0; k < NUM; k++) begin : g_sub
    assign w_norm[D_W*k +: D_W] = sat_sub(r_score[k], r_max);
  end

  // State register.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) r_state <= S_LOAD;
    else          r_state <= w_state_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    w_state_next = r_state;
    O_IN_RDY     = 1'b0;
    O_OUT_VLD    = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        O_IN_RDY = 1'b1;
        if (w_in_hs && w_cnt_last) w_state_next = S_SUB;
      end
      S_SUB:  w_state_next = S_RUN;
      S_RUN:  if (I_SM_VLD) w_state_next = S_OUT;
      S_OUT: begin
        O_OUT_VLD = 1'b1;
        if (w_out_hs && w_cnt_last) w_state_next = S_LOAD;
      end
      default: w_state_next = S_LOAD;
    endcase
  end

  assign O_OUT_LAST = O_OUT_VLD && w_cnt_last;
  assign O_OUT_DATA = O_OUT_VLD ? r_res[w_idx] : '0;
  assign O_BUSY     = !((r_state == S_LOAD) && (r_cnt == '0));

  // Control registers: word counter, running row max, engine start and row.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!I_RST_N) begin
      r_cnt      <= '0;
      r_max      <= SM_MIN;
      r_sm_start <= 1'b0;
      r_sm_data  <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: if (w_in_hs) begin
          r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
          if ($signed(I_IN_DATA) > $signed(r_max)) r_max <= I_IN_DATA;
        end
        S_SUB: begin
          r_sm_data  <= w_norm;
          r_sm_start <= 1'b1;
        end
        S_RUN: if (I_SM_VLD) r_sm_start <= 1'b0;
        S_OUT: if (w_out_hs) begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            r_max <= SM_MIN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Score and result buffers.
  always_ff @(posedge I_CLK) begin
    // NOTE: the buffers are left unreset; every word is written before it is
    // read in a row, and the output mux forces zero while no result is valid.
    if ((r_state == S_LOAD) && w_in_hs) r_score[w_idx] <= I_IN_DATA;
    if ((r_state == S_RUN) && I_SM_VLD) begin
      for (int k = 0; k < NUM; k++) r_res[k] <= I_SM_DATA[D_W*k +: D_W];
    end
  end

endmodule
